// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin decode arbiter.
package arb_pkg;
    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } state_t;
endpackage

// File: rtl/onehot_dec_3to8.sv
// Combinational 3-to-8 one-hot decoder.
module onehot_dec_3to8 (
    input  logic [2:0] idx,
    output logic [7:0] onehot
);
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/rr_decode_arbiter.sv
// 8-way round-robin arbiter with registered one-hot grant and dead cycle per hand-off.
// Hold timer present only when RR_ARB_HOLD_TIMEOUT_EN is defined; owner_release is the "release" input (keyword clash).
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ_P  = N_REQ,
    parameter int IDX_W_P  = IDX_W,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ_P-1:0] req,
    input  logic               owner_release,
    output logic [N_REQ_P-1:0] grant,
    output logic [IDX_W_P-1:0] grant_idx,
    output logic               grant_valid,
    output logic               timeout
);
    if (N_REQ_P != 8 || IDX_W_P != 3) begin : g_bad_width
        $error("rr_decode_arbiter supports exactly 8 requesters with a 3-bit index");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_decode_arbiter MAX_HOLD must be in 2..255");
    end

    state_t             state, state_n;
    logic [IDX_W_P-1:0] ptr, ptr_n, idx_n, win_idx, cand;
    logic [N_REQ_P-1:0] grant_r, grant_n, dec_out;
    logic               found, withdrawn, expired, revoke, timeout_n;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    logic [7:0] cnt, cnt_n;
    assign expired = (cnt == 8'(MAX_HOLD - 1));
`else
    assign expired = 1'b0;
`endif

    // Rotating priority scan: first set bit at or above ptr, wrapping.
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int i = 0; i < N_REQ_P; i++) begin
            cand = ptr + IDX_W_P'(i);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    onehot_dec_3to8 u_dec (
        .idx    (win_idx),
        .onehot (dec_out)
    );

    assign withdrawn = ~req[grant_idx];
    assign revoke    = owner_release | withdrawn | expired;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = grant_idx;
        grant_n   = grant_r;
        timeout_n = 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        cnt_n     = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_n = S_GRANT;
                    idx_n   = win_idx;
                    grant_n = dec_out;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            S_GRANT: begin
                if (revoke) begin
                    state_n   = S_IDLE;
                    grant_n   = '0;
                    ptr_n     = grant_idx + 1'b1;
                    // A coincident release or withdrawal makes this a normal revoke.
                    timeout_n = expired & ~owner_release & ~withdrawn;
                end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                else begin
                    cnt_n = cnt + 8'd1;
                end
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            grant_r   <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant_idx <= idx_n;
            grant_r   <= grant_n;
        end
    end

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout_n;
`endif

    assign grant_valid = (state == S_GRANT);
    // Mask keeps any stale decoder value off the port while idle.
    assign grant       = grant_r & {N_REQ_P{grant_valid}};
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (handles both hold-timer builds).
module tb_rr_decode_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int npass = 0;
    int ntot  = 0;

    rr_decode_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .owner_release (rel),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       t;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev, input logic et);
        ntot++;
        if (grant === eg && grant_idx === ei && grant_valid === ev && timeout === et)
            npass++;
        else
            $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                     name, grant, grant_idx, grant_valid, timeout, eg, ei, ev, et);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        rel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[3]  = '{8'h24, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[5]  = '{8'h24, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        vecs[7]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[10] = '{8'h06, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[11] = '{8'h06, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[12] = '{8'h06, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[13] = '{8'h06, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[14] = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[15] = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[16] = '{8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[17] = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        vecs[18] = '{8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};

        // Idle after reset
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Table: basic grant, hand-off, withdraw, no preemption, wrap
        for (int k = 0; k < 19; k++) begin
            req = vecs[k].req;
            rel = vecs[k].rel;
            tick();
            check($sformatf("vec%0d", k), vecs[k].g, vecs[k].idx, vecs[k].v, vecs[k].t);
        end

        // Full rotation with release each grant
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            rel = 1'b0;
            tick();
            check($sformatf("rot_grant%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            rel = 1'b1;
            tick();
            check($sformatf("rot_dead%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end
        rel = 1'b0;

        // Single persistent requester, no release
        do_reset();
        req = 8'h80;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("hold%0d", k), 8'h80, 3'd7, 1'b1, 1'b0);
        end
        tick();
        check("hold_timeout", 8'h00, 3'd7, 1'b0, 1'b1);
        tick();
        check("hold_regrant", 8'h80, 3'd7, 1'b1, 1'b0);
`else
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("hold%0d", k), 8'h80, 3'd7, 1'b1, 1'b0);
        end
`endif

        // Release coinciding with timer expiry: normal revoke
        do_reset();
        req = 8'h80;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("exp%0d", k), 8'h80, 3'd7, 1'b1, 1'b0);
        end
        rel = 1'b1;
        tick();
        check("exp_release", 8'h00, 3'd7, 1'b0, 1'b0);
        rel = 1'b0;
        tick();
        check("exp_regrant", 8'h80, 3'd7, 1'b1, 1'b0);

        // Asynchronous reset mid-grant
        do_reset();
        req = 8'h10;
        tick();
        check("pre_rst_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h11;
        @(negedge clk) rst = 1'b0;
        tick();
        check("post_rst_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
